// File: rtl/lzma_stream_framer.sv
// Buffers the raw LZMA byte stream in a FIFO and re-emits each frame on a valid/ready stream.
// Define LZMA_FRAMER_HEADER_EN to prefix every frame with the 13-byte LZMA-alone header.
module lzma_stream_framer #(
  parameter logic [31:0] DICT_SIZE = 32'h0000_1000,
  parameter int unsigned FIFO_AW   = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  input  logic        o_ready,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic        o_frame_done,
  output logic [31:0] o_frame_bytes,
  output logic        o_overflow
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_next;

  logic [8:0]       mem [0:DEPTH-1];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [8:0]       rd_entry;
  logic             avail, seen_last, hdr_load, done, hs, can_load;
  logic [3:0]       hidx;
  logic [7:0]       hdr_byte;
  logic [31:0]      pay_cnt;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push     = i_valid && !full;
  assign rd_entry = mem[rd_ptr[FIFO_AW-1:0]];
  assign hs       = o_valid && o_ready;
  assign can_load = !o_valid || o_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {i_last, i_data};
  end

  always_comb begin
    case (hidx)
      4'd0:    hdr_byte = 8'h5D;
      4'd1:    hdr_byte = DICT_SIZE[7:0];
      4'd2:    hdr_byte = DICT_SIZE[15:8];
      4'd3:    hdr_byte = DICT_SIZE[23:16];
      4'd4:    hdr_byte = DICT_SIZE[31:24];
      default: hdr_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // IDLE acts on a one-cycle-delayed non-empty flag: this gives the two-cycle first-byte
  // latency yet lets IDLE load the next frame's first byte directly (single bubble).
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    hdr_load   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (avail) begin
`ifdef LZMA_FRAMER_HEADER_EN
          state_next = HDR;
          hdr_load   = 1'b1;
`else
          state_next = DATA;
          pop        = 1'b1;
`endif
        end
      end
`ifdef LZMA_FRAMER_HEADER_EN
      HDR: begin
        if (can_load) begin
          hdr_load = 1'b1;
          if (hidx == 4'd12) state_next = DATA;
        end
      end
`endif
      DATA: begin
        if (can_load && !empty && !seen_last) pop = 1'b1;
        if (hs && o_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      avail         <= 1'b0;
      seen_last     <= 1'b0;
      hidx          <= '0;
      pay_cnt       <= '0;
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_last        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_bytes <= '0;
      o_overflow    <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      avail        <= !empty;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (i_valid && full) o_overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (hdr_load) begin
        o_valid <= 1'b1;
        o_data  <= hdr_byte;
        o_last  <= 1'b0;
        hidx    <= hidx + 1'b1;
      end else if (pop) begin
        o_valid   <= 1'b1;
        o_data    <= rd_entry[7:0];
        o_last    <= rd_entry[8];
        seen_last <= rd_entry[8];
        if (pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
      end else if (hs) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (done) begin
        o_frame_done  <= 1'b1;
        o_frame_bytes <= pay_cnt;
        pay_cnt       <= '0;
        seen_last     <= 1'b0;
        hidx          <= '0;
      end
    end
  end
endmodule
